// File: rtl/pwm_pkg.sv
// Shared mode encodings and duty-bus slicing for the multi-channel PWM.
// No logic, no latency, no flow control.
// Imported by the top and the per-channel comparator.
package pwm_pkg;

    localparam logic MODE_EDGE   = 1'b0;
    localparam logic MODE_CENTER = 1'b1;

    // LSB of channel ch inside a flat duty bus of width-bit lanes
    function automatic int duty_lsb(input int ch, input int width);
        return ch * width;
    endfunction

endpackage

// File: rtl/pwm_channel_cmp.sv
// One PWM lane: count-vs-duty compare, live polarity, registered output.
// Latency: output reflects the count one cycle later.
// No backpressure; idles at the polarity level while disabled.
module pwm_channel_cmp #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [WIDTH-1:0] count,
    input  logic [WIDTH-1:0] duty,
    input  logic             polarity,
    output logic             pwm_out
);

    logic raw;

    assign raw = (count < duty);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_out <= 1'b0;
        end else if (!enable) begin
            pwm_out <= polarity;
        end else begin
            pwm_out <= raw ^ polarity;
        end
    end

endmodule

// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM with a shared edge/center-aligned counter and double-buffered settings.
// Latency: outputs and period_start lag the counter by one cycle; loads apply at a period boundary.
// Backpressure: load_ready is low while a staged load waits for its boundary.
module pwm_multi_channel
    import pwm_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic                      load_valid,
    output logic                      load_ready,
    input  logic [WIDTH-1:0]          load_period,
    input  logic [CHANNELS*WIDTH-1:0] load_duty,
    input  logic                      load_center,
    input  logic [CHANNELS-1:0]       polarity,
    output logic [CHANNELS-1:0]       pwm_out,
    output logic                      period_start
);

    localparam logic [0:0]       ST_UP   = 1'b0;
    localparam logic [0:0]       ST_DOWN = 1'b1;
    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0]          cnt;
    logic [0:0]                dir;

    logic [WIDTH-1:0]          sh_period;
    logic [CHANNELS*WIDTH-1:0] sh_duty;
    logic                      sh_mode;

    logic                      stg_vld;
    logic [WIDTH-1:0]          stg_period;
    logic [CHANNELS*WIDTH-1:0] stg_duty;
    logic                      stg_mode;

    logic                      at_end;
    logic                      boundary;
    logic                      apply;
    logic                      accept;

    // Last cycle of the current period, judged on the shadow settings
    always_comb begin
        at_end = 1'b0;
        if (sh_period == '0) begin
            at_end = 1'b1;
        end else if (sh_mode == MODE_EDGE) begin
            at_end = (cnt == sh_period);
        end else begin
            at_end = (cnt == '0) && (dir == ST_DOWN);
        end
    end

    assign boundary   = enable & at_end;
    assign apply      = stg_vld & (boundary | ~enable);
    assign load_ready = ~stg_vld;
    assign accept     = load_valid & load_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            dir <= ST_UP;
        end else if (!enable || at_end) begin
            cnt <= '0;
            dir <= ST_UP;
        end else if (sh_mode == MODE_EDGE) begin
            cnt <= cnt + ONE;
        end else if (dir == ST_UP) begin
            // top value is held for a second cycle while turning around
            if (cnt == sh_period - ONE) begin
                dir <= ST_DOWN;
            end else begin
                cnt <= cnt + ONE;
            end
        end else begin
            cnt <= cnt - ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_vld    <= 1'b0;
            stg_period <= '0;
            stg_duty   <= '0;
            stg_mode   <= MODE_EDGE;
        end else if (apply) begin
            stg_vld <= 1'b0;
        end else if (accept) begin
            stg_vld    <= 1'b1;
            stg_period <= load_period;
            stg_duty   <= load_duty;
            stg_mode   <= load_center;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_period <= '1;
            sh_duty   <= '0;
            sh_mode   <= MODE_EDGE;
        end else if (apply) begin
            sh_period <= stg_period;
            sh_duty   <= stg_duty;
            sh_mode   <= stg_mode;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_start <= 1'b0;
        end else begin
            period_start <= enable && (cnt == '0) && (dir == ST_UP);
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        pwm_channel_cmp #(
            .WIDTH(WIDTH)
        ) u_cmp (
            .clk     (clk),
            .rst_n   (rst_n),
            .enable  (enable),
            .count   (cnt),
            .duty    (sh_duty[duty_lsb(i, WIDTH) +: WIDTH]),
            .polarity(polarity[i]),
            .pwm_out (pwm_out[i])
        );
    end

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Directed bench for pwm_multi_channel: edge, center, double-buffering, polarity/enable, corners, reset.
module tb_pwm_multi_channel;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        load_valid;
    logic        load_ready;
    logic [7:0]  load_period;
    logic [31:0] load_duty;
    logic        load_center;
    logic [3:0]  polarity;
    logic [3:0]  pwm_out;
    logic        period_start;

    int n_checks = 0;
    int n_fail   = 0;

    pwm_multi_channel #(
        .CHANNELS(4),
        .WIDTH   (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_period (load_period),
        .load_duty   (load_duty),
        .load_center (load_center),
        .polarity    (polarity),
        .pwm_out     (pwm_out),
        .period_start(period_start)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // count value shown by the outputs k cycles into a run
    function automatic int cnt_at(input int k, input int p, input bit center);
        int per;
        int ph;
        if (p == 0) return 0;
        per = center ? 2 * p : p + 1;
        ph  = k % per;
        if (!center) return ph;
        return (ph < p) ? ph : 2 * p - 1 - ph;
    endfunction

    function automatic logic [3:0] pwm_exp(input int c, input logic [31:0] d, input logic [3:0] pol);
        logic [3:0] r;
        logic [7:0] dv;
        for (int i = 0; i < 4; i++) begin
            dv   = d[i*8 +: 8];
            r[i] = (c < int'({24'd0, dv})) ^ pol[i];
        end
        return r;
    endfunction

    task automatic check_cycle(input string tag, input int k, input int p, input bit center,
                               input logic [31:0] d);
        int per;
        per = (p == 0) ? 1 : (center ? 2 * p : p + 1);
        check({tag, "_pwm"}, 32'(pwm_out), 32'(pwm_exp(cnt_at(k, p, center), d, polarity)));
        check({tag, "_ps"}, 32'(period_start), 32'((k % per) == 0));
    endtask

    task automatic do_load(input logic [7:0] p, input logic [31:0] d, input logic c);
        check("load_rdy_before", 32'(load_ready), 32'd1);
        load_valid  = 1'b1;
        load_period = p;
        load_duty   = d;
        load_center = c;
        tick();
        load_valid  = 1'b0;
    endtask

    // disable, load through the idle path, re-enable; returns at output cycle 0
    task automatic start_run(input logic [7:0] p, input logic [31:0] d, input logic c);
        enable = 1'b0;
        tick();
        check("idle_pwm", 32'(pwm_out), 32'(polarity));
        check("idle_ps", 32'(period_start), 32'd0);
        do_load(p, d, c);
        tick();
        check("idle_applied_rdy", 32'(load_ready), 32'd1);
        enable = 1'b1;
        tick();
    endtask

    initial begin
        logic [31:0] d_old;
        logic [31:0] d7;
        logic [31:0] d2;
        logic [31:0] dcur;

        rst_n       = 1'b1;
        enable      = 1'b0;
        load_valid  = 1'b0;
        load_period = 8'd0;
        load_duty   = 32'd0;
        load_center = 1'b0;
        polarity    = 4'b0000;
        #2 rst_n = 1'b0;
        #2;
        check("rst_pwm", 32'(pwm_out), 32'd0);
        check("rst_ps", 32'(period_start), 32'd0);
        check("rst_rdy", 32'(load_ready), 32'd1);
        check("rst_cnt", 32'(dut.cnt), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // edge mode: P=9, duties ch0..ch3 = 0,3,10,9
        start_run(8'd9, 32'h090A0300, 1'b0);
        for (int k = 0; k < 20; k++) begin
            check_cycle("edge", k, 9, 1'b0, 32'h090A0300);
            tick();
        end

        // center mode: P=4, ch0 duty 2
        start_run(8'd4, 32'h00000002, 1'b1);
        for (int k = 0; k < 16; k++) begin
            check_cycle("center", k, 4, 1'b1, 32'h00000002);
            tick();
        end

        // double buffering, rejected second load, load in the boundary cycle, polarity toggle
        d_old = 32'h00000300;
        d7    = 32'h00000700;
        d2    = 32'h00000200;
        start_run(8'd9, d_old, 1'b0);
        for (int k = 0; k < 40; k++) begin
            dcur = (k < 10) ? d_old : ((k < 30) ? d7 : d2);
            check_cycle("dbuf", k, 9, 1'b0, dcur);
            if (k >= 5 && k <= 8)   check("dbuf_rdy_low", 32'(load_ready), 32'd0);
            if (k == 9)             check("dbuf_rdy_back", 32'(load_ready), 32'd1);
            if (k >= 19 && k <= 28) check("bnd_rdy_low", 32'(load_ready), 32'd0);
            if (k == 29)            check("bnd_rdy_back", 32'(load_ready), 32'd1);
            if (k == 4) begin
                load_valid = 1'b1;
                load_duty  = d7;
            end
            if (k == 5) load_duty = 32'h00000100;
            if (k == 7) load_valid = 1'b0;
            if (k == 18) begin
                check("bnd_rdy", 32'(load_ready), 32'd1);
                load_valid = 1'b1;
                load_duty  = d2;
            end
            if (k == 19) load_valid = 1'b0;
            if (k == 33) polarity = 4'b0010;
            tick();
        end

        // enable low forces inactive level and counter 0
        enable = 1'b0;
        tick();
        check("dis_pwm", 32'(pwm_out), 32'h2);
        check("dis_ps", 32'(period_start), 32'd0);
        check("dis_cnt", 32'(dut.cnt), 32'd0);
        polarity = 4'b1010;
        tick();
        check("dis_pol_pwm", 32'(pwm_out), 32'hA);
        enable = 1'b1;
        tick();
        check("reen_ps", 32'(period_start), 32'd1);
        check("reen_pwm", 32'(pwm_out), 32'(pwm_exp(0, d2, 4'b1010)));
        tick();
        check("reen_ps_next", 32'(period_start), 32'd0);
        polarity = 4'b0000;

        // P = 0: every cycle a boundary, outputs constant per duty
        start_run(8'd0, 32'h00050100, 1'b0);
        for (int k = 0; k < 5; k++) begin
            check("p0_pwm", 32'(pwm_out), 32'h6);
            check("p0_ps", 32'(period_start), 32'd1);
            tick();
        end

        // async reset mid-period with a load pending
        load_valid  = 1'b1;
        load_period = 8'd7;
        load_duty   = 32'h01010101;
        tick();
        load_valid = 1'b0;
        check("pre_rst_rdy", 32'(load_ready), 32'd0);
        check("pre_rst_pwm", 32'(pwm_out), 32'h6);
        #3 rst_n = 1'b0;
        #1;
        check("arst_pwm", 32'(pwm_out), 32'd0);
        check("arst_ps", 32'(period_start), 32'd0);
        check("arst_rdy", 32'(load_ready), 32'd1);
        check("arst_cnt", 32'(dut.cnt), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
